vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_timing_sync_delay.sv | 24 ++
 rtl/vga_timing.sv | 110 +++++++++++
 tb/tb_vga_timing.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing constants and the sync bundle carried through the delay line.
package vga_pkg;
    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam int H_TOTAL        = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL        = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int MAX_PIPE_DELAY = 4;

    // Logical (active-high) levels; polarity is applied only at the pins.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;
endpackage

// File: rtl/vga_timing_sync_delay.sv
// sync_delay: DEPTH-stage shift register of sync_t that resets to all-inactive.
module sync_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  sync_t i_sync,
    output sync_t o_sync
);
    sync_t r_pipe [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) r_pipe[k] <= '0;
        end else begin
            r_pipe[0] <= i_sync;
            for (int k = 1; k < DEPTH; k++) r_pipe[k] <= r_pipe[k-1];
        end
    end

    assign o_sync = r_pipe[DEPTH-1];
endmodule

// File: rtl/vga_timing.sv
// vga_timing: raster counters with registered enable/line/frame strobes and
// PIPE_DELAY-aligned sync/DE outputs; i_run low parks the raster at 0/0.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit SYNC_NEG   = 1'b1,
    parameter int PIPE_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_run,
    output logic        o_newframe,
    output logic        o_newline,
    output logic        o_enable,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic [15:0] o_frame_cnt
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT + 1);
    localparam int VW    = $clog2(V_TOT + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOT <= H_ACTIVE || V_TOT <= V_ACTIVE) begin : g_bad_total
        $error("vga_timing: totals must exceed active size");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > MAX_PIPE_DELAY) begin : g_bad_delay
        $error("vga_timing: PIPE_DELAY out of range 0..4");
    end

    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic          r_active;
    sync_t         r_sync;
    logic [HW-1:0] w_h_nxt;
    logic [VW-1:0] w_v_nxt;
    logic          w_restart;
    logic          w_h_wrap;
    logic          w_nl_nxt;
    logic          w_nf_nxt;
    sync_t         w_sync_nxt;
    sync_t         w_dly;

    // The first running edge after idle/reset lands on 0/0 instead of advancing.
    always_comb begin
        w_restart     = !i_run || !r_active;
        w_h_wrap      = r_hcnt == H_LAST;
        w_h_nxt       = (w_restart || w_h_wrap) ? '0 : r_hcnt + 1'b1;
        w_v_nxt       = w_restart ? '0 : !w_h_wrap ? r_vcnt : (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
        w_nl_nxt      = i_run && w_h_nxt == H_LAST;
        w_nf_nxt      = w_nl_nxt && w_v_nxt == V_LAST;
        w_sync_nxt.hs = i_run && w_h_nxt >= HS_BEG && w_h_nxt < HS_END;
        w_sync_nxt.vs = i_run && w_v_nxt >= VS_BEG && w_v_nxt < VS_END;
        w_sync_nxt.de = i_run && w_h_nxt < H_ACT && w_v_nxt < V_ACT;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_active    <= 1'b0;
            r_sync      <= '0;
            o_newline   <= 1'b0;
            o_newframe  <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            r_hcnt      <= w_h_nxt;
            r_vcnt      <= w_v_nxt;
            r_active    <= i_run;
            r_sync      <= w_sync_nxt;
            o_newline   <= w_nl_nxt;
            o_newframe  <= w_nf_nxt;
            o_frame_cnt <= o_newframe ? o_frame_cnt + 16'd1 : o_frame_cnt;
        end
    end

    if (PIPE_DELAY == 0) begin : g_bypass
        assign w_dly = r_sync;
    end else begin : g_delay
        sync_delay #(.DEPTH(PIPE_DELAY)) u_sync_delay (
            .clk    (clk),
            .rst    (rst),
            .i_sync (r_sync),
            .o_sync (w_dly)
        );
    end

    assign o_enable = r_sync.de;
    assign o_hsync  = w_dly.hs ^ SYNC_NEG;
    assign o_vsync  = w_dly.vs ^ SYNC_NEG;
    assign o_de     = w_dly.de;
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: default timing at PIPE_DELAY 0 and 3 plus a shrunken raster
// (25x13, positive syncs, PIPE_DELAY 1) for whole-frame, run-gap and reset checks.
module tb_vga_timing;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_run;
    logic [2:0]  en, nl, nf, hs, vs, de;
    logic [15:0] fc0, fc3, fcs;
    int          p = -1;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    vga_timing #(.PIPE_DELAY(0)) u_p0 (
        .clk(clk), .rst(rst), .i_run(i_run), .o_newframe(nf[0]), .o_newline(nl[0]),
        .o_enable(en[0]), .o_hsync(hs[0]), .o_vsync(vs[0]), .o_de(de[0]), .o_frame_cnt(fc0));
    vga_timing #(.PIPE_DELAY(3)) u_p3 (
        .clk(clk), .rst(rst), .i_run(i_run), .o_newframe(nf[1]), .o_newline(nl[1]),
        .o_enable(en[1]), .o_hsync(hs[1]), .o_vsync(vs[1]), .o_de(de[1]), .o_frame_cnt(fc3));
    vga_timing #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3), .V_ACTIVE(8), .V_FP(2),
                 .V_SYNC(1), .V_BP(2), .SYNC_NEG(1'b0), .PIPE_DELAY(1)) u_sm (
        .clk(clk), .rst(rst), .i_run(i_run), .o_newframe(nf[2]), .o_newline(nl[2]),
        .o_enable(en[2]), .o_hsync(hs[2]), .o_vsync(vs[2]), .o_de(de[2]), .o_frame_cnt(fcs));

    typedef struct {
        int   p;
        logic en, nl, hs0, hs3, de3;
    } vec_t;

    int   c_en = 0, c_nl = 0, c_nf = 0, c_hs = 0, c_vs = 0, c_de = 0, c_ovl = 0, c_nonl = 0;
    int   nf_p [2] = '{-1, -1};
    logic sm_hs [650];
    logic sm_vs [650];
    logic [15:0] fc649, fc650;

    // Small-raster observer over its first two frames (p = 0..649).
    always @(negedge clk) begin
        if (rst && p >= 0 && p < 650) begin
            c_en   += int'(en[2]);
            c_nl   += int'(nl[2]);
            c_hs   += int'(hs[2]);
            c_vs   += int'(vs[2]);
            c_de   += int'(de[2]);
            c_ovl  += int'(nf[2] & en[2]);
            c_nonl += int'(nf[2] & !nl[2]);
            if (nf[2]) begin
                if (c_nf < 2) nf_p[c_nf] = p;
                c_nf++;
            end
            sm_hs[p] = hs[2];
            sm_vs[p] = vs[2];
            if (p == 649) fc649 = fcs;
        end
        if (rst && p == 650) fc650 = fcs;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (p=%0d)", nm, got, exp, p);
        end
    endtask

    task automatic step();
        @(posedge clk);
        p++;
        @(negedge clk);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_out"}, 64'({en, nl, nf, hs, vs, de}), 64'(18'b000_000_000_011_011_000));
        chk({nm, "_fc"}, {16'h0, fc0, fc3, fcs}, 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [18];
        int   nf_low;
        int   nf_q;
        tbl[0]  = '{0,   1, 0, 1, 1, 0};
        tbl[1]  = '{2,   1, 0, 1, 1, 0};
        tbl[2]  = '{3,   1, 0, 1, 1, 1};
        tbl[3]  = '{639, 1, 0, 1, 1, 1};
        tbl[4]  = '{640, 0, 0, 1, 1, 1};
        tbl[5]  = '{642, 0, 0, 1, 1, 1};
        tbl[6]  = '{643, 0, 0, 1, 1, 0};
        tbl[7]  = '{655, 0, 0, 1, 1, 0};
        tbl[8]  = '{656, 0, 0, 0, 1, 0};
        tbl[9]  = '{658, 0, 0, 0, 1, 0};
        tbl[10] = '{659, 0, 0, 0, 0, 0};
        tbl[11] = '{751, 0, 0, 0, 0, 0};
        tbl[12] = '{752, 0, 0, 1, 0, 0};
        tbl[13] = '{754, 0, 0, 1, 0, 0};
        tbl[14] = '{755, 0, 0, 1, 1, 0};
        tbl[15] = '{799, 0, 1, 1, 1, 0};
        tbl[16] = '{800, 1, 0, 1, 1, 0};
        tbl[17] = '{803, 1, 0, 1, 1, 1};

        rst   = 1'b0;
        i_run = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            while (p < tbl[i].p) step();
            chk($sformatf("line_vec%0d", tbl[i].p),
                64'({en[1], en[0], nl[0], nf[0], hs[0], vs[0], de[0], nl[1], nf[1], hs[1], vs[1], de[1]}),
                64'({tbl[i].en, tbl[i].en, tbl[i].nl, 1'b0, tbl[i].hs0, 1'b1, tbl[i].en,
                     tbl[i].nl, 1'b0, tbl[i].hs3, 1'b1, tbl[i].de3}));
        end

        chk("sm_enable_cycles", 64'(c_en), 64'(256));
        chk("sm_newline_pulses", 64'(c_nl), 64'(26));
        chk("sm_newframe_pulses", 64'(c_nf), 64'(2));
        chk("sm_newframe_pos0", 64'(nf_p[0]), 64'(324));
        chk("sm_newframe_pos1", 64'(nf_p[1]), 64'(649));
        chk("sm_hsync_cycles", 64'(c_hs), 64'(104));
        chk("sm_vsync_cycles", 64'(c_vs), 64'(50));
        chk("sm_de_cycles", 64'(c_de), 64'(256));
        chk("sm_nf_en_overlap", 64'(c_ovl), 64'(0));
        chk("sm_nf_without_nl", 64'(c_nonl), 64'(0));
        chk("sm_frame_cnt", {32'h0, fc649, fc650}, {32'h0, 16'd1, 16'd2});
        chk("sm_hsync_edges", 64'({sm_hs[18], sm_hs[19], sm_hs[22], sm_hs[23]}), 64'(4'b0110));
        chk("sm_vsync_edges", 64'({sm_vs[250], sm_vs[251], sm_vs[275], sm_vs[276]}), 64'(4'b0110));

        // Run gap: small raster at line 3 pixel 19, inside its hsync.
        while (p < 1069) step();
        chk("pre_drop", 64'({hs[2], de[1], fcs}), 64'({1'b1, 1'b1, 16'd3}));
        i_run = 1'b0;
        step();
        chk("drop_strobes", 64'({en, nl, nf}), 64'(0));
        chk("drop_pipe_e1", 64'({hs[0], de[0], hs[2], de[1]}), 64'(4'b1011));
        step();
        chk("drop_sm_drain", 64'({hs[2], de[2]}), 64'(0));
        step();
        step();
        chk("drop_p3_drain", 64'({de[1], hs[1]}), 64'(2'b01));
        nf_low = 0;
        while (p < 1079) begin
            step();
            nf_low += int'(|nf);
        end
        chk("drop_hold", 64'({en, nf, fcs, fc0}), 64'({3'b0, 3'b0, 16'd3, 16'd0}));
        chk("drop_no_newframe", 64'(nf_low), 64'(0));
        i_run = 1'b1;
        step();
        chk("resume_q0", 64'({en, nf, fcs}), 64'({3'b111, 3'b000, 16'd3}));
        nf_q = -1;
        for (int q = 1; q <= 325; q++) begin
            step();
            if (nf[2] && nf_q < 0) nf_q = q;
        end
        chk("resume_first_nf", 64'(nf_q), 64'(324));
        chk("resume_frame_cnt", 64'(fcs), 64'(4));

        // Reset mid-line while the default raster is in hsync.
        while (p < 1080 + 700) step();
        chk("pre_rst_hsync", 64'({hs[0], hs[1], en[0]}), 64'(0));
        #2;
        rst = 1'b0;
        #1;
        chk_idle("async_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
